// File: rtl/axi4_lite_slave.sv
// axi4_lite_slave: AXI4-Lite register-file slave with NUM_REGS 32-bit registers.
// The write and read channels are independent. Each channel has its own
// two-state FSM, and every handshake output is driven from a register.
// Optional build macro: AXI4_LITE_SLAVE_SLVERR_EN. When it is defined,
// out-of-range accesses answer SLVERR (2'b10). When it is not defined,
// they answer OKAY (2'b00). In both builds, out-of-range writes are
// dropped and out-of-range reads return zero.
module axi4_lite_slave #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int NUM_REGS      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   // write address channel
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [ADDRESS_WIDTH-1:0]  awaddr,
   // write data channel
   input  logic                      wvalid,
   output logic                      wready,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [DATA_WIDTH/8-1:0]   wstrb,
   // write response channel
   output logic                      bvalid,
   input  logic                      bready,
   output logic [1:0]                bresp,
   // read address channel
   input  logic                      arvalid,
   output logic                      arready,
   input  logic [ADDRESS_WIDTH-1:0]  araddr,
   // read data channel
   output logic                      rvalid,
   input  logic                      rready,
   output logic [DATA_WIDTH-1:0]     rdata,
   output logic [1:0]                rresp
);

   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam int STRB_W = DATA_WIDTH / 8;
   // Byte addresses at or above this limit fall outside the register file.
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT = ADDRESS_WIDTH'(NUM_REGS * 4);
   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_SLAVE_SLVERR_EN
   localparam logic [1:0] RESP_OOR  = 2'b10;
`else
   localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

   typedef enum logic {W_ACCEPT, W_RESP} w_state_t;
   typedef enum logic {R_ACCEPT, R_DATA} r_state_t;

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   // ------------------------------------------------------------------
   // Write path state
   // ------------------------------------------------------------------
   w_state_t                 w_state_q;
   logic                     aw_held_q;
   logic                     w_held_q;
   logic [ADDRESS_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic [STRB_W-1:0]        wstrb_q;
   logic                     awready_q;
   logic                     wready_q;
   logic                     bvalid_q;
   logic [1:0]               bresp_q;

   logic                     aw_hs;
   logic                     w_hs;
   logic                     aw_have;
   logic                     w_have;
   logic [ADDRESS_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0]    wr_data;
   logic [STRB_W-1:0]        wr_strb;
   logic                     wr_in_range;
   logic                     wr_commit;
   logic                     wr_en;
   logic [IDX_W-1:0]         wr_idx;

   assign aw_hs   = awvalid && awready_q;
   assign w_hs    = wvalid && wready_q;
   // Each half of the write counts as present if it was latched earlier
   // or if it is handshaking on this edge.
   assign aw_have = aw_held_q || aw_hs;
   assign w_have  = w_held_q || w_hs;

   // A handshake on this edge takes priority over the latched copy.
   // This lets the commit happen on the same edge as the later handshake.
   assign wr_addr     = aw_hs ? awaddr : awaddr_q;
   assign wr_data     = w_hs  ? wdata  : wdata_q;
   assign wr_strb     = w_hs  ? wstrb  : wstrb_q;
   assign wr_in_range = (wr_addr < ADDR_LIMIT);
   assign wr_idx      = wr_addr[2 +: IDX_W];
   assign wr_commit   = (w_state_q == W_ACCEPT) && aw_have && w_have;
   assign wr_en       = wr_commit && wr_in_range;

   // Write FSM: collect AW and W in either order, commit, then hold the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_ACCEPT;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
      end else begin
         case (w_state_q)
            W_ACCEPT: begin
               if (aw_hs) begin
                  awaddr_q <= awaddr;
               end
               if (w_hs) begin
                  wdata_q <= wdata;
                  wstrb_q <= wstrb;
               end
               if (wr_commit) begin
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wr_in_range ? RESP_OKAY : RESP_OOR;
                  aw_held_q <= 1'b0;
                  w_held_q  <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  w_state_q <= W_RESP;
               end else begin
                  aw_held_q <= aw_have;
                  w_held_q  <= w_have;
                  awready_q <= !aw_have;
                  wready_q  <= !w_have;
               end
            end
            W_RESP: begin
               // Both flags are already clear, so both channels reopen together.
               if (bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  w_state_q <= W_ACCEPT;
               end
            end
            default: begin
               w_state_q <= W_ACCEPT;
            end
         endcase
      end
   end

   // One write-enabled register slot per index, with per-byte strobe merge.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [DATA_WIDTH-1:0] reg_d;
         for (genvar gb = 0; gb < STRB_W; gb++) begin : g_byte
            assign reg_d[gb*8 +: 8] = wr_strb[gb] ? wr_data[gb*8 +: 8]
                                                  : regs_q[gi][gb*8 +: 8];
         end

         // Load the merged word when this slot is the committed write target.
         always_ff @(posedge clk) begin
            if (rst) begin
               regs_q[gi] <= '0;
            end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
               regs_q[gi] <= reg_d;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------
   r_state_t              r_state_q;
   logic                  arready_q;
   logic                  rvalid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q;

   logic                  ar_hs;
   logic                  rd_in_range;
   logic [IDX_W-1:0]      rd_idx;

   assign ar_hs       = arvalid && arready_q;
   assign rd_in_range = (araddr < ADDR_LIMIT);
   assign rd_idx      = araddr[2 +: IDX_W];

   // Read FSM: capture the register on AR handshake and hold the beat until rready.
   // The register array is sampled before any same-edge write lands.
   // A read that collides with a write to the same register therefore
   // returns the old contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_ACCEPT;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
      end else begin
         case (r_state_q)
            R_ACCEPT: begin
               if (ar_hs) begin
                  rdata_q   <= rd_in_range ? regs_q[rd_idx] : '0;
                  rresp_q   <= rd_in_range ? RESP_OKAY : RESP_OOR;
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  r_state_q <= R_DATA;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  r_state_q <= R_ACCEPT;
               end
            end
            default: begin
               r_state_q <= R_ACCEPT;
            end
         endcase
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

endmodule
